axil_mem_arbiter: RTL

//  Shares the single downstream AXI-lite memory port between instruction fetch (read-only) and the

---
 rtl/axil_mem_arbiter_if.sv | 38 +++
 rtl/axil_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_arbiter_if.sv
// AXI-lite bundle shared by the fetch, memoryrw and downstream memory ports of the arbiter.
// Latency: none; this file only carries wires.
// Backpressure: standard AXI-lite valid/ready on every channel.
// Ports (modports):
//   rd_slv / rd_mst : AR + R channels, seen from the responder / requester side
//   wr_slv / wr_mst : AW + W + B channels, seen from the responder / requester side
interface axil_interface_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport rd_slv (input  araddr, arvalid, rready,
                    output arready, rdata, rresp, rvalid);
    modport rd_mst (output araddr, arvalid, rready,
                    input  arready, rdata, rresp, rvalid);
    modport wr_slv (input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    output awready, wready, bresp, bvalid);
    modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    input  awready, wready, bresp, bvalid);
endinterface

// File: rtl/axil_mem_arbiter.sv
// Shares one downstream AXI-lite memory port between fetch (read-only) and memoryrw (read+write).
// Latency: 0 cycles on every channel (AR/R/AW/W/B paths are combinational; only grant/FIFO/count are state).
// Backpressure: AR stalls when the read-ID FIFO is full or a DMEM read waits on open writes; AW/W stall at the write-count limit.
// Ports:
//   clk, rst (async active-low)      ; imem_rd/dmem_rd (rd_slv) upstream reads, dmem_wr (wr_slv) upstream writes
//   mem_rd (rd_mst), mem_wr (wr_mst) downstream memory ; imem_flush in ; idle, rd_resp_err out
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating AR priority (default: fixed DMEM > IMEM).
module axil_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_WR_OUTSTAND = 4
) (
    input  logic             clk,
    input  logic             rst,
    axil_interface_if.rd_slv imem_rd,
    axil_interface_if.rd_slv dmem_rd,
    axil_interface_if.wr_slv dmem_wr,
    axil_interface_if.rd_mst mem_rd,
    axil_interface_if.wr_mst mem_wr,
    input  logic             imem_flush,
    output logic             idle,
    output logic             rd_resp_err
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_WR_OUTSTAND + 1);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IMEM = 2'd1;
    localparam logic [1:0] GNT_DMEM = 2'd2;

    localparam logic ID_IMEM = 1'b0;
    localparam logic ID_DMEM = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] id_q;
    logic [MAX_OUTSTANDING-1:0] drop_q;
    logic [1:0]                 gnt_q;
    logic [CNT_W-1:0]           wr_cnt_q;

    // ------------------------------------------------------------------
    // Read-ID FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] fill;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             fifo_empty;
    logic             fifo_full;
    logic             head_id;
    logic             head_drop;
    logic             pop;
    logic             space;

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == PTR_W'(MAX_OUTSTANDING));
    // Depth is a power of two, so the modulo is just the low pointer bits.
    assign wr_idx     = IDX_W'(wr_ptr_q % PTR_W'(MAX_OUTSTANDING));
    assign rd_idx     = IDX_W'(rd_ptr_q % PTR_W'(MAX_OUTSTANDING));
    assign head_id    = id_q[rd_idx];
    // A flush in the same cycle as the head beat already kills that beat.
    assign head_drop  = drop_q[rd_idx] || (imem_flush && (head_id == ID_IMEM));

    // ------------------------------------------------------------------
    // R routing
    // ------------------------------------------------------------------
    assign imem_rd.rdata = mem_rd.rdata;
    assign imem_rd.rresp = mem_rd.rresp;
    assign dmem_rd.rdata = mem_rd.rdata;
    assign dmem_rd.rresp = mem_rd.rresp;

    always_comb begin
        imem_rd.rvalid = 1'b0;
        dmem_rd.rvalid = 1'b0;
        // Empty FIFO or dropped head: swallow whatever arrives.
        mem_rd.rready  = 1'b1;
        if (!fifo_empty && !head_drop) begin
            if (head_id == ID_DMEM) begin
                dmem_rd.rvalid = mem_rd.rvalid;
                mem_rd.rready  = dmem_rd.rready;
            end else begin
                imem_rd.rvalid = mem_rd.rvalid;
                mem_rd.rready  = imem_rd.rready;
            end
        end
    end

    assign pop   = mem_rd.rvalid && mem_rd.rready && !fifo_empty;
    // A beat leaving this cycle frees its slot for an AR accepted in the same cycle.
    assign space = !fifo_full || pop;

    // ------------------------------------------------------------------
    // AR arbitration
    // ------------------------------------------------------------------
    logic       dmem_elig;
    logic [1:0] pick;
    logic [1:0] sel;
    logic [1:0] gnt_d;
    logic       ar_fire;
    logic       push_id;

    // DMEM reads wait for all open writes so a read never overtakes a write.
    assign dmem_elig = dmem_rd.arvalid && (wr_cnt_q == '0);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    always_comb begin
        pick = GNT_NONE;
        if (space) begin
            if (dmem_elig && imem_rd.arvalid) begin
                pick = (last_q == ID_DMEM) ? GNT_IMEM : GNT_DMEM;
            end else if (dmem_elig) begin
                pick = GNT_DMEM;
            end else if (imem_rd.arvalid) begin
                pick = GNT_IMEM;
            end
        end
    end

    // Reset value IMEM makes DMEM win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= ID_IMEM;
        end else if (ar_fire) begin
            last_q <= push_id;
        end
    end
`else
    always_comb begin
        pick = GNT_NONE;
        if (space) begin
            if (dmem_elig) begin
                pick = GNT_DMEM;
            end else if (imem_rd.arvalid) begin
                pick = GNT_IMEM;
            end
        end
    end
`endif

    // A registered grant is held until accepted, regardless of the other requester.
    assign sel = (gnt_q == GNT_NONE) ? pick : gnt_q;

    assign mem_rd.araddr  = (sel == GNT_DMEM) ? dmem_rd.araddr : imem_rd.araddr;
    assign mem_rd.arvalid = ((sel == GNT_DMEM) && dmem_rd.arvalid) ||
                            ((sel == GNT_IMEM) && imem_rd.arvalid);
    assign imem_rd.arready = (sel == GNT_IMEM) && mem_rd.arready;
    assign dmem_rd.arready = (sel == GNT_DMEM) && mem_rd.arready;

    assign ar_fire = mem_rd.arvalid && mem_rd.arready;
    assign push_id = (sel == GNT_DMEM) ? ID_DMEM : ID_IMEM;

    always_comb begin
        gnt_d = gnt_q;
        if (gnt_q == GNT_NONE) begin
            if ((pick != GNT_NONE) && !mem_rd.arready) begin
                gnt_d = pick;
            end
        end else if (ar_fire) begin
            gnt_d = GNT_NONE;
        end
        // A redirect withdraws a pending fetch request; fetch drops its valid itself.
        if (imem_flush && (gnt_d == GNT_IMEM)) begin
            gnt_d = GNT_NONE;
        end
    end

    // ------------------------------------------------------------------
    // FIFO entry update: push, then flush marks every IMEM entry
    // (including the one pushed this cycle).
    // ------------------------------------------------------------------
    logic [MAX_OUTSTANDING-1:0] id_d;
    logic [MAX_OUTSTANDING-1:0] drop_d;

    always_comb begin
        id_d   = id_q;
        drop_d = drop_q;
        if (ar_fire) begin
            id_d[wr_idx]   = push_id;
            drop_d[wr_idx] = 1'b0;
        end
        if (imem_flush) begin
            // Free slots may get marked too; a push always clears its own bit.
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (id_d[i] == ID_IMEM) begin
                    drop_d[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write pass-through with open-write limit
    // ------------------------------------------------------------------
    logic wr_full;
    logic aw_fire;
    logic b_fire;

    assign wr_full = (wr_cnt_q == CNT_W'(MAX_WR_OUTSTAND));

    assign mem_wr.awaddr   = dmem_wr.awaddr;
    assign mem_wr.awvalid  = dmem_wr.awvalid && !wr_full;
    assign mem_wr.wdata    = dmem_wr.wdata;
    assign mem_wr.wstrb    = dmem_wr.wstrb;
    assign mem_wr.wvalid   = dmem_wr.wvalid && !wr_full;
    assign mem_wr.bready   = 1'b1;
    assign dmem_wr.awready = mem_wr.awready && !wr_full;
    assign dmem_wr.wready  = mem_wr.wready && !wr_full;
    assign dmem_wr.bvalid  = mem_wr.bvalid;
    assign dmem_wr.bresp   = mem_wr.bresp;

    assign aw_fire = mem_wr.awvalid && mem_wr.awready;
    assign b_fire  = mem_wr.bvalid;

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    assign idle = fifo_empty && (wr_cnt_q == '0) && !imem_rd.arvalid && !dmem_rd.arvalid;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            id_q        <= '0;
            drop_q      <= '0;
            gnt_q       <= GNT_NONE;
            wr_cnt_q    <= '0;
            rd_resp_err <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            id_q   <= id_d;
            drop_q <= drop_d;
            if (ar_fire) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // Simultaneous AW and B leave the count unchanged.
            if (aw_fire && !b_fire) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end else if (!aw_fire && b_fire && (wr_cnt_q != '0)) begin
                wr_cnt_q <= wr_cnt_q - CNT_W'(1);
            end
            if (mem_rd.rvalid && fifo_empty) begin
                rd_resp_err <= 1'b1;
            end
        end
    end
endmodule
